sbox_arbiter: RTL and testbench

- Shares one bank of 4 masked S-box instances (gen_bp_sbox, one 32-bit column per issue) between two requesters: the round datapath (DP) and the key schedule (KS).
- Arbitrates issue slots and gates issue on PRNG randomness availability.
- Tracks in-flight ownership through a tag pipeline matching the S-box latency, and routes each result back to its owner.
- Sits between the AES32 core datapath/key schedule and the S-box bank.

---
 rtl/sbox_arb_pkg.sv | 19 +
 rtl/sbox_tag_pipe.sv | 51 +++++
 rtl/sbox_arbiter.sv | 111 +++++++++++
 tb/tb_sbox_arbiter.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sbox_arb_pkg.sv
// sbox_arb_pkg: shared definitions for the S-box bank arbiter.
//   COL_W   - width of one unshared column (4 bytes).
//   owner_e - which requester owns an in-flight op (datapath or key schedule).
//   tag_t   - one tag-pipeline stage: {valid, owner}.
package sbox_arb_pkg;

    localparam int unsigned COL_W = 32;

    typedef enum logic {
        OWN_DP = 1'b0,
        OWN_KS = 1'b1
    } owner_e;

    typedef struct packed {
        logic   valid;
        owner_e owner;
    } tag_t;

endpackage

// File: rtl/sbox_tag_pipe.sv
// sbox_tag_pipe: LAT-deep shift register of {valid, owner} tags that tracks
// ops travelling through the S-box bank. Shifts every cycle, never stalls.
// Ports:
//   clk, rst             - clock, synchronous active-high reset (clears all tags)
//   in_valid, in_owner   - tag loaded into stage 0 this cycle
//   out_valid, out_owner - tag in the last stage (result owner this cycle)
//   busy                 - OR of all stage valid bits
module sbox_tag_pipe
    import sbox_arb_pkg::*;
#(
    parameter int unsigned LAT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic in_valid,
    input  logic in_owner,
    output logic out_valid,
    output logic out_owner,
    output logic busy
);

    tag_t [LAT-1:0] tags_q;
    tag_t [LAT-1:0] tags_d;

    always_comb begin
        tags_d          = tags_q;
        tags_d[0].valid = in_valid;
        tags_d[0].owner = owner_e'(in_owner);
        for (int unsigned i = 1; i < LAT; i++) begin
            tags_d[i] = tags_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tags_q <= '0;
        end else begin
            tags_q <= tags_d;
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int unsigned i = 0; i < LAT; i++) begin
            busy = busy | tags_q[i].valid;
        end
        out_valid = tags_q[LAT-1].valid;
        out_owner = tags_q[LAT-1].owner;
    end

endmodule

// File: rtl/sbox_arbiter.sv
// sbox_arbiter: shares one masked S-box bank (one shared 32-bit column per
// issue) between the round datapath (DP) and the key schedule (KS).
// Round-robin arbitration, issue gated on PRNG randomness, ownership tracked
// through a tag pipeline matching the bank latency, results routed back.
// Ports:
//   clk, rst                  - clock, synchronous active-high reset
//   dp_in_valid/ready/data    - DP column request (32*d shared bits)
//   ks_in_valid/ready/data    - KS column request
//   rnd_valid, rnd_ready      - PRNG randomness available / consumed
//   sb_in, sb_out             - to / from the S-box bank
//   dp_out_valid/data         - DP result, no backpressure
//   ks_out_valid/data         - KS result, no backpressure
//   busy                      - any op in flight
//   rnd_err                   - sticky: randomness starved while busy
module sbox_arbiter
    import sbox_arb_pkg::*;
#(
    parameter int unsigned d   = 2,
    parameter int unsigned LAT = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 dp_in_valid,
    output logic                 dp_in_ready,
    input  logic [COL_W*d-1:0]   dp_in_data,
    input  logic                 ks_in_valid,
    output logic                 ks_in_ready,
    input  logic [COL_W*d-1:0]   ks_in_data,
    input  logic                 rnd_valid,
    output logic                 rnd_ready,
    output logic [COL_W*d-1:0]   sb_in,
    input  logic [COL_W*d-1:0]   sb_out,
    output logic                 dp_out_valid,
    output logic [COL_W*d-1:0]   dp_out_data,
    output logic                 ks_out_valid,
    output logic [COL_W*d-1:0]   ks_out_data,
    output logic                 busy,
    output logic                 rnd_err
);

    owner_e last_grant_q, last_grant_d;
    logic   rnd_err_q, rnd_err_d;

    logic issue;
    logic grant_dp, grant_ks;
    logic tag_valid, tag_owner, pipe_busy;

    // Grant and issue: purely combinational from the valids, never from ready.
    always_comb begin
        if (dp_in_valid && ks_in_valid) begin
            grant_ks = (last_grant_q == OWN_DP);
            grant_dp = ~grant_ks;
        end else begin
            grant_ks = ks_in_valid;
            grant_dp = dp_in_valid;
        end
        issue       = (dp_in_valid | ks_in_valid) & rnd_valid & ~rst;
        dp_in_ready = issue & grant_dp;
        ks_in_ready = issue & grant_ks;

        // Zero when idle so stale shares never reach the bank.
        sb_in = '0;
        if (dp_in_ready) begin
            sb_in = dp_in_data;
        end else if (ks_in_ready) begin
            sb_in = ks_in_data;
        end

        last_grant_d = last_grant_q;
        if (issue) begin
            last_grant_d = grant_ks ? OWN_KS : OWN_DP;
        end

        rnd_err_d = rnd_err_q | (pipe_busy & ~rnd_valid);
    end

    // Reset pointer to "DP granted last" so KS wins the first contested slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= OWN_DP;
            rnd_err_q    <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            rnd_err_q    <= rnd_err_d;
        end
    end

    sbox_tag_pipe #(
        .LAT (LAT)
    ) u_tag_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (issue),
        .in_owner  (grant_ks),
        .out_valid (tag_valid),
        .out_owner (tag_owner),
        .busy      (pipe_busy)
    );

    // Result routing from the last tag stage.
    always_comb begin
        dp_out_valid = tag_valid & ~tag_owner;
        ks_out_valid = tag_valid & tag_owner;
        dp_out_data  = dp_out_valid ? sb_out : '0;
        ks_out_data  = ks_out_valid ? sb_out : '0;
        busy         = pipe_busy;
        rnd_ready    = issue | pipe_busy;
        rnd_err      = rnd_err_q;
    end

endmodule

// File: tb/tb_sbox_arbiter.sv
// tb_sbox_arbiter: directed bench for sbox_arbiter with a behavioural masked
// S-box bank (AES S-box per byte, fresh output share split, LAT-cycle delay).
module tb_sbox_arbiter;

    localparam int unsigned D   = 2;
    localparam int unsigned LAT = 4;
    localparam int unsigned W   = 32 * D;
    localparam int G_NONE = 0;
    localparam int G_DP   = 1;
    localparam int G_KS   = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         dp_in_valid, ks_in_valid, rnd_valid;
    logic [W-1:0] dp_in_data, ks_in_data;
    logic         dp_in_ready, ks_in_ready, rnd_ready;
    logic [W-1:0] sb_in, sb_out;
    logic         dp_out_valid, ks_out_valid, busy, rnd_err;
    logic [W-1:0] dp_out_data, ks_out_data;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    logic exp_err = 1'b0;

    logic        exp_dv  [256];
    logic        exp_kv  [256];
    logic [31:0] exp_val [256];
    logic        iss     [256];

    logic [W-1:0] bank [LAT];

    always #5 clk = ~clk;

    sbox_arbiter #(
        .d   (D),
        .LAT (LAT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .dp_in_valid  (dp_in_valid),
        .dp_in_ready  (dp_in_ready),
        .dp_in_data   (dp_in_data),
        .ks_in_valid  (ks_in_valid),
        .ks_in_ready  (ks_in_ready),
        .ks_in_data   (ks_in_data),
        .rnd_valid    (rnd_valid),
        .rnd_ready    (rnd_ready),
        .sb_in        (sb_in),
        .sb_out       (sb_out),
        .dp_out_valid (dp_out_valid),
        .dp_out_data  (dp_out_data),
        .ks_out_valid (ks_out_valid),
        .ks_out_data  (ks_out_data),
        .busy         (busy),
        .rnd_err      (rnd_err)
    );

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = '0;
        logic [7:0] x = a;
        logic [7:0] y = b;
        logic       hi;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            hi = x[7];
            x  = x << 1;
            if (hi) x = x ^ 8'h1b;
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [15:0] t = {v, v};
        t = t << n;
        return t[15:8];
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] r = 8'h01;
        logic [7:0] p = x;
        for (int i = 1; i < 8; i++) begin
            p = gmul(p, p);
            r = gmul(r, p);
        end
        return r ^ rotl8(r, 1) ^ rotl8(r, 2) ^ rotl8(r, 3) ^ rotl8(r, 4) ^ 8'h63;
    endfunction

    function automatic logic [31:0] sbox_col(input logic [31:0] v);
        logic [31:0] o;
        for (int b = 0; b < 4; b++) o[8*b +: 8] = sbox(v[8*b +: 8]);
        return o;
    endfunction

    function automatic logic [W-1:0] share(input logic [31:0] v);
        logic [W-1:0] o;
        logic         acc, r;
        for (int unsigned k = 0; k < 32; k++) begin
            acc = 1'b0;
            for (int unsigned s = 0; s < D - 1; s++) begin
                r = 1'($urandom_range(0, 1));
                o[k*D + s] = r;
                acc = acc ^ r;
            end
            o[k*D + D - 1] = v[k] ^ acc;
        end
        return o;
    endfunction

    function automatic logic [31:0] unshare(input logic [W-1:0] x);
        logic [31:0] v;
        for (int unsigned k = 0; k < 32; k++) begin
            v[k] = 1'b0;
            for (int unsigned s = 0; s < D; s++) v[k] = v[k] ^ x[k*D + s];
        end
        return v;
    endfunction

    // Behavioural masked S-box bank.
    always @(posedge clk) begin
        bank[0] <= share(sbox_col(unshare(sb_in)));
        for (int i = 1; i < LAT; i++) bank[i] <= bank[i-1];
    end
    assign sb_out = bank[LAT-1];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s cyc=%0d: observed %0h expected %0h", tag, cyc, obs, expv);
        end
    endtask

    task automatic clear_sb();
        for (int i = 0; i < 256; i++) begin
            exp_dv[i] = 1'b0; exp_kv[i] = 1'b0; exp_val[i] = '0; iss[i] = 1'b0;
        end
    endtask

    // Drive one cycle's inputs and check every output at the negedge.
    task automatic step(input logic dv, input logic [31:0] dval, input logic kv,
                        input logic [31:0] kval, input logic rv, input int eg);
        logic         eb;
        logic [W-1:0] exp_sb;
        dp_in_valid = dv;
        dp_in_data  = dv ? share(dval) : '0;
        ks_in_valid = kv;
        ks_in_data  = kv ? share(kval) : '0;
        rnd_valid   = rv;
        eb = 1'b0;
        for (int k = 1; k <= int'(LAT); k++) if (cyc - k >= 0 && iss[cyc-k]) eb = 1'b1;
        @(negedge clk);
        chk("dp_in_ready", 64'(dp_in_ready), 64'(eg == G_DP));
        chk("ks_in_ready", 64'(ks_in_ready), 64'(eg == G_KS));
        exp_sb = (eg == G_DP) ? dp_in_data : (eg == G_KS) ? ks_in_data : '0;
        chk("sb_in", sb_in, exp_sb);
        chk("rnd_ready", 64'(rnd_ready), 64'((eg != G_NONE) | eb));
        chk("busy", 64'(busy), 64'(eb));
        chk("rnd_err", 64'(rnd_err), 64'(exp_err));
        chk("dp_out_valid", 64'(dp_out_valid), 64'(exp_dv[cyc]));
        chk("ks_out_valid", 64'(ks_out_valid), 64'(exp_kv[cyc]));
        if (exp_dv[cyc]) chk("dp_out_data", 64'(unshare(dp_out_data)), 64'(sbox_col(exp_val[cyc])));
        else             chk("dp_out_zero", dp_out_data, '0);
        if (exp_kv[cyc]) chk("ks_out_data", 64'(unshare(ks_out_data)), 64'(sbox_col(exp_val[cyc])));
        else             chk("ks_out_zero", ks_out_data, '0);
        if (eg != G_NONE) begin
            iss[cyc] = 1'b1;
            if (eg == G_DP) exp_dv[cyc+LAT] = 1'b1;
            else            exp_kv[cyc+LAT] = 1'b1;
            exp_val[cyc+LAT] = (eg == G_DP) ? dval : kval;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n, input logic rv);
        for (int i = 0; i < n; i++) begin
            step(1'b0, '0, 1'b0, '0, rv, G_NONE);
            tick();
        end
    endtask

    task automatic do_reset();
        dp_in_valid = 1'b0; ks_in_valid = 1'b0; rnd_valid = 1'b1;
        dp_in_data = '0; ks_in_data = '0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_sb();
        exp_err = 1'b0;
        cyc = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] dp_cols [4];
        logic [31:0] ks_cols [4];
        dp_cols[0] = 32'h00112233; dp_cols[1] = 32'h44556677;
        dp_cols[2] = 32'h8899AABB; dp_cols[3] = 32'hDEADBEEF;
        ks_cols[0] = 32'hCCDDEEFF; ks_cols[1] = 32'h01234567;
        ks_cols[2] = 32'h89ABCDEF; ks_cols[3] = 32'hCAFEF00D;

        rst = 1'b1;
        dp_in_valid = 1'b0; ks_in_valid = 1'b0; rnd_valid = 1'b0;
        dp_in_data = '0; ks_in_data = '0;
        clear_sb();

        // Reset state.
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_dp_in_ready", 64'(dp_in_ready), 64'(0));
        chk("rst_ks_in_ready", 64'(ks_in_ready), 64'(0));
        chk("rst_rnd_ready", 64'(rnd_ready), 64'(0));
        chk("rst_sb_in", sb_in, '0);
        chk("rst_dp_out_valid", 64'(dp_out_valid), 64'(0));
        chk("rst_dp_out_data", dp_out_data, '0);
        chk("rst_ks_out_valid", 64'(ks_out_valid), 64'(0));
        chk("rst_ks_out_data", ks_out_data, '0);
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_rnd_err", 64'(rnd_err), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        cyc = 0;

        // Single DP request: bytes 00,53,01,FF -> 63,ED,7C,16 after LAT cycles.
        step(1'b1, 32'hFF015300, 1'b0, '0, 1'b1, G_DP); tick();
        idle(int'(LAT) - 1, 1'b1);
        step(1'b0, '0, 1'b0, '0, 1'b1, G_NONE);
        chk("t1_sbox_bytes", 64'(unshare(dp_out_data)), 64'h167CED63);
        tick();
        idle(2, 1'b1);

        // Both valid for 6 cycles: KS, DP, KS, DP, KS, DP.
        for (int i = 0; i < 6; i++) begin
            step(1'b1, dp_cols[i/2], 1'b1, ks_cols[(i+1)/2], 1'b1, (i % 2 == 0) ? G_KS : G_DP);
            tick();
        end
        idle(int'(LAT) + 1, 1'b1);

        // No randomness: nothing issues, no error while idle; then KS first.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 32'h0BADF00D, 1'b1, 32'h600DCAFE, 1'b0, G_NONE);
            tick();
        end
        step(1'b1, 32'h0BADF00D, 1'b1, 32'h600DCAFE, 1'b1, G_KS); tick();
        idle(int'(LAT) + 1, 1'b1);

        // Three DP ops, then starve randomness while busy.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, dp_cols[i], 1'b0, '0, 1'b1, G_DP);
            tick();
        end
        step(1'b0, '0, 1'b0, '0, 1'b0, G_NONE); tick();
        exp_err = 1'b1;
        step(1'b0, '0, 1'b0, '0, 1'b0, G_NONE); tick();
        idle(int'(LAT) + 1, 1'b1);

        // Two KS ops then reset: results dropped, pointer back to KS-first.
        step(1'b0, '0, 1'b1, ks_cols[0], 1'b1, G_KS); tick();
        step(1'b0, '0, 1'b1, ks_cols[1], 1'b1, G_KS); tick();
        do_reset();
        step(1'b0, '0, 1'b0, '0, 1'b0, G_NONE); tick();
        step(1'b1, dp_cols[3], 1'b1, ks_cols[3], 1'b1, G_KS); tick();
        idle(int'(LAT) + 2, 1'b1);

        // Continuous DP stream of 16 columns.
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 32'h13579BDF ^ (32'h01010101 * i), 1'b0, '0, 1'b1, G_DP);
            tick();
        end
        idle(int'(LAT) + 2, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
